// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the execute-stage branch resolution unit:
// condition codes, FSM encoding and the sequential-PC increment.
package branch_resolve_pkg;

  typedef enum logic [2:0] {
    FT_NEQ = 3'b000,
    FT_EQ  = 3'b001,
    FT_LT  = 3'b010,
    FT_LTZ = 3'b101,
    FT_LEZ = 3'b110,
    FT_GTZ = 3'b111
  } ft_e;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  localparam int PC_INC = 4;

  // Two-operand compares use rt; the zero-compares force the subtrahend to 0.
  function automatic logic ft_uses_b(input logic [2:0] ft);
    return (ft == FT_NEQ) || (ft == FT_EQ) || (ft == FT_LT);
  endfunction

endpackage

// File: rtl/branch_resolve_flags.sv
// Combinational subtract producing zero / signed-negative / overflow flags
// for the branch comparison.
module branch_flags #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              zero,
  output logic              negative,
  output logic              overflow
);

  logic [DATA_W-1:0] diff;

  assign diff     = a - b;
  assign zero     = (diff == '0);
  assign overflow = (a[DATA_W-1] ^ b[DATA_W-1]) & (diff[DATA_W-1] ^ a[DATA_W-1]);
  // Correcting the sign bit by overflow yields the true signed a < b.
  assign negative = diff[DATA_W-1] ^ overflow;

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: evaluates the condition code from the
// comparison flags and turns a taken branch into a held redirect plus flush.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic [2:0]        ex_ft,
  input  logic [DATA_W-1:0] ex_a,
  input  logic [DATA_W-1:0] ex_b,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [PC_W-1:0]   ex_offset,
  input  logic              stall,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush,
  output logic              cmp_zero,
  output logic              cmp_negative,
  output logic              cmp_overflow,
  output logic              ft_err,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_e            state, state_next;
  logic [DATA_W-1:0] b_eff;
  logic              taken, ft_known, resolve;

  assign b_eff = ft_uses_b(ex_ft) ? ex_b : '0;

  branch_flags #(.DATA_W(DATA_W)) u_flags (
    .a        (ex_a),
    .b        (b_eff),
    .zero     (cmp_zero),
    .negative (cmp_negative),
    .overflow (cmp_overflow)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    taken    = 1'b0;
    ft_known = 1'b1;
    case (ex_ft)
      FT_NEQ:  taken = ~cmp_zero;
      FT_EQ:   taken = cmp_zero;
      FT_LT:   taken = cmp_negative;
      FT_LTZ:  taken = cmp_negative;
      FT_LEZ:  taken = cmp_negative | cmp_zero;
      FT_GTZ:  taken = ~cmp_negative & ~cmp_zero;
      default: ft_known = 1'b0;
    endcase
  end

  // Wrong-path EX contents are ignored while a redirect is pending.
  assign resolve = (state == IDLE) & ex_valid & ex_branch;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (resolve && taken) state_next = PEND;
      PEND:    if (!stall)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      redirect_pc <= '0;
      ft_err      <= 1'b0;
      br_cnt      <= '0;
      taken_cnt   <= '0;
    end else begin
      state  <= state_next;
      ft_err <= resolve & ~ft_known;
      if (resolve && taken)
        redirect_pc <= ex_pc + PC_W'(PC_INC) + ex_offset;
      if (resolve && (br_cnt != {CNT_W{1'b1}}))
        br_cnt <= br_cnt + CNT_W'(1);
      if (resolve && taken && (taken_cnt != {CNT_W{1'b1}}))
        taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

  assign redirect_valid = (state == PEND);
  assign flush          = (state == PEND);

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized self-checking bench for branch_resolve: a 16-bit-counter and a
// 2-bit-counter instance share stimulus and are compared to a behavioural model.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_branch, stall;
  logic [2:0]  ex_ft;
  logic [31:0] ex_a, ex_b, ex_pc, ex_offset;

  logic        rv, fl, cz, cn, co, fe;
  logic [31:0] rpc;
  logic [15:0] bc, tc;
  logic        rv_s, fl_s, cz_s, cn_s, co_s, fe_s;
  logic [31:0] rpc_s;
  logic [1:0]  bc_s, tc_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_pend;
  logic [31:0] m_rpc;
  int          m_br, m_tk;
  bit          m_err;

  always #5 clk = ~clk;

  branch_resolve #(.DATA_W(32), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_ft(ex_ft), .ex_a(ex_a), .ex_b(ex_b), .ex_pc(ex_pc), .ex_offset(ex_offset),
    .stall(stall), .redirect_valid(rv), .redirect_pc(rpc), .flush(fl),
    .cmp_zero(cz), .cmp_negative(cn), .cmp_overflow(co), .ft_err(fe),
    .br_cnt(bc), .taken_cnt(tc)
  );

  branch_resolve #(.DATA_W(32), .PC_W(32), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_ft(ex_ft), .ex_a(ex_a), .ex_b(ex_b), .ex_pc(ex_pc), .ex_offset(ex_offset),
    .stall(stall), .redirect_valid(rv_s), .redirect_pc(rpc_s), .flush(fl_s),
    .cmp_zero(cz_s), .cmp_negative(cn_s), .cmp_overflow(co_s), .ft_err(fe_s),
    .br_cnt(bc_s), .taken_cnt(tc_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // One clock cycle: apply inputs, check flags, advance model, check registers.
  task automatic step(input bit v, input bit br, input logic [2:0] ft,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] off,
                      input bit st, input bit rs);
    logic [31:0] bp;
    longint      d;
    bit          z, n, ov, known, tk, res;
    ex_valid = v; ex_branch = br; ex_ft = ft; ex_a = a; ex_b = b;
    ex_pc = pc; ex_offset = off; stall = st; reset = rs;
    #1;
    known = !(ft == 3'b011 || ft == 3'b100);
    bp    = (ft == 3'b000 || ft == 3'b001 || ft == 3'b010) ? b : 32'h0;
    d     = longint'($signed(a)) - longint'($signed(bp));
    z     = (a == bp);
    n     = (d < 0);
    ov    = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    if (known) begin
      check("zero", cz, z);
      check("negative", cn, n);
      check("overflow", co, ov);
      check("small_zero", cz_s, z);
    end
    case (ft)
      3'b000:  tk = !z;
      3'b001:  tk = z;
      3'b010:  tk = n;
      3'b101:  tk = n;
      3'b110:  tk = n || z;
      3'b111:  tk = !n && !z;
      default: tk = 1'b0;
    endcase
    res = !m_pend && v && br;
    @(posedge clk);
    if (!rs) begin
      m_pend = 0; m_rpc = 0; m_br = 0; m_tk = 0; m_err = 0;
    end else begin
      m_err = res && !known;
      if (m_pend) begin
        if (!st) m_pend = 0;
      end else if (res && tk) begin
        m_pend = 1;
        m_rpc  = pc + 32'd4 + off;
      end
      if (res) begin
        m_br++;
        if (tk) m_tk++;
      end
    end
    #1;
    check("redirect_valid", rv, m_pend);
    check("flush", fl, m_pend);
    check("redirect_pc", rpc, m_rpc);
    check("ft_err", fe, m_err);
    check("br_cnt", bc, sat(m_br, 65535));
    check("taken_cnt", tc, sat(m_tk, 65535));
    check("small_redirect_valid", rv_s, m_pend);
    check("small_flush", fl_s, m_pend);
    check("small_redirect_pc", rpc_s, m_rpc);
    check("small_ft_err", fe_s, m_err);
    check("small_br_cnt", bc_s, sat(m_br, 3));
    check("small_taken_cnt", tc_s, sat(m_tk, 3));
  endtask

  task automatic idle(input bit st);
    step(0, 0, 3'b000, 0, 0, 0, 0, st, 1);
  endtask

  initial begin
    logic [31:0] a, b;
    m_pend = 0; m_rpc = 0; m_br = 0; m_tk = 0; m_err = 0;

    // Reset state
    step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    check("reset_rv", rv, 1'b0);
    check("reset_br_cnt", bc, 16'd0);

    // EQ taken, no stall: one-cycle redirect to 0x124
    step(1, 1, 3'b001, 5, 5, 32'h100, 32'h20, 0, 1);
    check("eq_rv", rv, 1'b1);
    check("eq_rpc", rpc, 32'h124);
    check("eq_br_cnt", bc, 16'd1);
    check("eq_taken_cnt", tc, 16'd1);
    idle(0);
    check("eq_rv_drop", rv, 1'b0);

    // LT with signed overflow, taken / not taken
    step(1, 1, 3'b010, 32'h8000_0000, 32'h1, 32'h200, 32'h40, 0, 1);
    idle(0);
    step(1, 1, 3'b010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h300, 32'h40, 0, 1);
    check("lt_nt_rv", rv, 1'b0);

    // Zero-compares ignore ex_b
    step(1, 1, 3'b111, 0, 32'hFFFF_FFFF, 32'h400, 32'h8, 0, 1);
    check("gtz_zero_nt", rv, 1'b0);
    step(1, 1, 3'b110, 0, 32'hFFFF_FFFF, 32'h500, 32'h8, 0, 1);
    check("lez_zero_tk", rv, 1'b1);
    idle(0);

    // Stall for 3 cycles; wrong-path taken branches in EX are ignored
    step(1, 1, 3'b000, 1, 2, 32'h1000, 32'hFFFF_FFF0, 1, 1);
    for (int i = 0; i < 3; i++)
      step(1, 1, 3'b001, 7, 7, 32'h2000 + 32'(i), 32'h100, (i < 2), 1);
    check("stall_rpc_const", rpc, 32'h0FF4);
    idle(0);
    check("stall_released", rv, 1'b0);

    // Undefined condition codes
    step(1, 1, 3'b011, 3, 3, 32'h600, 32'h4, 0, 1);
    check("ft011_err", fe, 1'b1);
    step(1, 1, 3'b100, 3, 0, 32'h600, 32'h4, 0, 1);
    idle(0);
    check("ft_err_pulse_end", fe, 1'b0);

    // Back-to-back not-taken branches
    for (int i = 0; i < 4; i++)
      step(1, 1, 3'b000, 32'(i), 32'(i), 32'h700, 0, 0, 1);

    // Reset while a redirect is pending
    step(1, 1, 3'b001, 9, 9, 32'h800, 32'h10, 1, 1);
    step(0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
    check("rst_pend_rv", rv, 1'b0);
    check("rst_pend_cnt", bc, 16'd0);

    // Five taken branches saturate the 2-bit counters
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 3'b001, 1, 1, 32'h900, 32'(4 * i), 0, 1);
      idle(0);
    end
    check("sat_small_taken", tc_s, 2'd3);
    check("sat_big_taken", tc, 16'd5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 32'h0;
        1:       a = 32'h8000_0000;
        2:       a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom);
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)), a, b, $urandom, $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 149) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit for the pipelined CPU. It is the flag-producing side of branch comparison. It subtracts the branch operands to form Zero/Negative/Overflow, evaluates the branch condition code, and turns a taken branch into a registered redirect plus pipeline flush. Front-end prediction is static not-taken. The redirect is held under stall until the fetch stage accepts it.

## Interface
- DATA_W, 32, operand width
- PC_W, 32, program-counter width
- CNT_W, 16, width of the saturating performance counters
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset; state is cleared on a rising edge while reset=0
- ex_valid  in  1  EX stage holds a live instruction
- ex_branch  in  1  EX instruction is a conditional branch
- ex_ft  in  3  condition code (see Operation)
- ex_a, ex_b  in  DATA_W  operands (rs, rt)
- ex_pc  in  PC_W  branch instruction address
- ex_offset  in  PC_W  sign-extended byte offset
- stall  in  1  front end cannot accept a redirect this cycle
- redirect_valid  out  1  redirect request pending
- redirect_pc  out  PC_W  target address
- flush  out  1  squash IF/ID/EX wrong-path instructions
- cmp_zero, cmp_negative, cmp_overflow  out  1 each  combinational flags of current EX operands
- ft_err  out  1  one-cycle pulse: branch resolved with an undefined ex_ft
- br_cnt, taken_cnt  out  CNT_W  resolved / taken branch counters

## Operation
- Flag arithmetic:
  - diff = A − B' modulo 2^DATA_W, where B' = ex_b for EQ/NEQ/LT and B' = 0 for LEZ/LTZ/GTZ.
  - cmp_zero = (diff == 0).
  - cmp_overflow = (A[msb] ≠ B'[msb]) & (diff[msb] ≠ A[msb]).
  - cmp_negative = diff[msb] ^ cmp_overflow, i.e. true signed A < B'.
- Condition codes (ex_ft):
  - NEQ 000: ~Z
  - EQ 001: Z
  - LT 010: N
  - LTZ 101: N
  - LEZ 110: N|Z
  - GTZ 111: ~N&~Z
  - 011 and 100 are undefined: taken = 0, ft_err pulses.
- Resolve event: state IDLE & ex_valid & ex_branch. Ignored when ex_branch = 0 or ex_valid = 0.
- Target: ex_pc + 4 + ex_offset, modulo 2^PC_W.
- States:
  - IDLE: on a resolve with taken = 1, latch the target and go to PEND. Not-taken resolves stay in IDLE.
  - PEND: redirect_valid = 1 and flush = 1. All EX inputs are ignored, since they are wrong-path. Go to IDLE at the first cycle with stall = 0; that cycle is the acceptance.
- Counters: on every resolve, br_cnt += 1. If taken, taken_cnt += 1 as well. Both saturate at 2^CNT_W − 1.
- Reset:
  - State returns to IDLE.
  - redirect_valid = 0, flush = 0, ft_err = 0, redirect_pc = 0, counters = 0.
  - A pending redirect is dropped.
- stall is ignored in IDLE. Resolution is never delayed by stall.

## Timing
- Resolve in cycle T (sampled at edge T/T+1). redirect_valid, flush and redirect_pc are valid from cycle T+1.
- With stall = 0 in T+1: the redirect lasts exactly one cycle and IDLE is reached at T+2. A branch present in EX at T+2 resolves normally.
- With stall = 1 for k cycles from T+1: the redirect is held for k+1 cycles and redirect_pc is stable throughout.
- ft_err is asserted in T+1 for one cycle.
- Counters update at the edge ending T.
- Flags are purely combinational from EX inputs, with zero latency.
- Back-to-back not-taken branches resolve every cycle.

## Structure
- Shared package holds:
  - FT codes FT_NEQ, FT_EQ, FT_LT, FT_LTZ, FT_LEZ, FT_GTZ
  - state encoding IDLE/PEND
  - the PC increment constant 4
- Sub-module branch_flags (DATA_W): pure combinational subtract producing Z/N/V. The top instantiates it once.

## Test plan
- EQ, A=5, B=5, pc=0x100, off=0x20, stall=0 → redirect_valid=1 for one cycle at T+1, redirect_pc=0x124, flush=1; br_cnt=1, taken_cnt=1.
- LT, A=0x80000000, B=1 → V=1, N=1, taken; LT with A=0x7FFFFFFF, B=0xFFFFFFFF → V=1, N=0, not taken, no redirect.
- GTZ with A=0, then LEZ with A=0, each with ex_b=0xFFFFFFFF → B forced 0: GTZ is not taken, LEZ is taken.
- Taken branch with stall=1 for 3 cycles → redirect_valid high 4 cycles with a constant target. A taken branch in EX during PEND is ignored and does not change the counters.
- ex_ft=011 → taken=0, ft_err pulse at T+1, br_cnt increments, no redirect.
- reset=0 during PEND → next cycle redirect_valid=0, flush=0, counters=0; with CNT_W=2 and 5 taken branches → counters stick at 3.
